// File: rtl/wm_cfg_regfile_mc.sv
// wm_cfg_regfile_mc
// APB register file holding the watermark configuration of NUM_CH independent
// embedding channels. Each channel has shadow config registers, a validated
// one-cycle start pulse and an IDLE/BUSY tracker closed by the core's
// Image_Done, plus sticky done / cfg_err status bits.
// Address: PADDR[3:0] register index, PADDR[7:4] channel.
// Optional feature: define WM_CFG_PSLVERR_EN to add the PSLVERR output, which
// flags invalid accesses, locked writes, rejected starts and STATUS writes.
module wm_cfg_regfile_mc #(
    parameter int NUM_CH          = 2,
    parameter int DATA_DEPTH      = 8,
    parameter int AMBA_WORD       = 16,
    parameter int AMBA_ADDR_DEPTH = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AMBA_ADDR_DEPTH-1:0]   PADDR,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [AMBA_WORD-1:0]         PWDATA,
    output logic [AMBA_WORD-1:0]         PRDATA,
    input  logic [NUM_CH-1:0]            Image_Done,
    output logic [NUM_CH-1:0]            start,
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH*DATA_DEPTH-1:0] WhitePixel,
    output logic [NUM_CH*7-1:0]          M,
    output logic [NUM_CH*10-1:0]         ImgSize,
    output logic [NUM_CH*8-1:0]          EdgeThr,
    output logic [NUM_CH*7-1:0]          Amin,
    output logic [NUM_CH*7-1:0]          Amax,
    output logic [NUM_CH*6-1:0]          Bmin,
    output logic [NUM_CH*6-1:0]          Bmax
`ifdef WM_CFG_PSLVERR_EN
    ,
    output logic                         PSLVERR
`endif
);

    localparam logic [3:0] IDX_CTRL   = 4'd0;
    localparam logic [3:0] IDX_WHITE  = 4'd1;
    localparam logic [3:0] IDX_M      = 4'd2;
    localparam logic [3:0] IDX_IMG    = 4'd3;
    localparam logic [3:0] IDX_THR    = 4'd4;
    localparam logic [3:0] IDX_AMIN   = 4'd5;
    localparam logic [3:0] IDX_AMAX   = 4'd6;
    localparam logic [3:0] IDX_BMIN   = 4'd7;
    localparam logic [3:0] IDX_BMAX   = 4'd8;
    localparam logic [3:0] IDX_STATUS = 4'd9;

    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ch_state_e;

    // Per-channel state and configuration
    ch_state_e             state_q [NUM_CH];
    logic [DATA_DEPTH-1:0] white_q [NUM_CH];
    logic [6:0]            m_q     [NUM_CH];
    logic [9:0]            img_q   [NUM_CH];
    logic [7:0]            thr_q   [NUM_CH];
    logic [6:0]            amin_q  [NUM_CH];
    logic [6:0]            amax_q  [NUM_CH];
    logic [5:0]            bmin_q  [NUM_CH];
    logic [5:0]            bmax_q  [NUM_CH];
    logic [NUM_CH-1:0]     start_q;
    logic [NUM_CH-1:0]     done_q;
    logic [NUM_CH-1:0]     err_q;
    logic [AMBA_WORD-1:0]  prdata_q;
    logic [AMBA_WORD-1:0]  rd_data_d;

    // APB phase decode
    logic [3:0]        addr_ch;
    logic [3:0]        addr_idx;
    logic              addr_ok;
    logic              wr_access;
    logic              rd_setup;
    logic              rd_access;
    logic [NUM_CH-1:0] sel_ch;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] cfg_ok;
    logic              unused_apb;

    assign addr_ch   = PADDR[7:4];
    assign addr_idx  = PADDR[3:0];
    assign addr_ok   = ({1'b0, addr_ch} < NUM_CH_W) && (addr_idx <= IDX_STATUS);
    assign wr_access = PSEL & PENABLE & PWRITE;
    assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
    assign rd_access = PSEL & PENABLE & ~PWRITE;
    assign ch_wr     = sel_ch & {NUM_CH{wr_access}};
    // Upper address bits and wide data bits carry no meaning here.
    assign unused_apb = ^{PADDR, PWDATA};

    // Channel select and start-parameter validation per channel
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
        sel_ch = '0;
        cfg_ok = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_ch[c] = addr_ok && (addr_ch == 4'(c));
            cfg_ok[c] = (m_q[c] != 7'd0) && ({3'b000, m_q[c]} <= img_q[c]) &&
                        (amin_q[c] <= amax_q[c]) && (bmin_q[c] <= bmax_q[c]);
        end
    end

    // Per-channel FSM: start pulse, busy tracking, sticky done / cfg_err
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) state_q[c] <= ST_IDLE;
            start_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                start_q[c] <= 1'b0;
                case (state_q[c])
                    ST_IDLE: begin
                        if (ch_wr[c] && addr_idx == IDX_CTRL) begin
                            // Clear is applied before start; start overrides where it fires.
                            if (PWDATA[1]) done_q[c] <= 1'b0;
                            if (PWDATA[0]) begin
                                if (cfg_ok[c]) begin
                                    start_q[c] <= 1'b1;
                                    state_q[c] <= ST_BUSY;
                                    done_q[c]  <= 1'b0;
                                    err_q[c]   <= 1'b0;
                                end else begin
                                    err_q[c] <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_BUSY: begin
                        // A start request here is ignored; completion wins over a clear.
                        if (ch_wr[c] && addr_idx == IDX_CTRL && PWDATA[1]) done_q[c] <= 1'b0;
                        if (Image_Done[c]) begin
                            state_q[c] <= ST_IDLE;
                            done_q[c]  <= 1'b1;
                        end
                    end
                    default: state_q[c] <= ST_IDLE;
                endcase
            end
        end
    end

    // Configuration registers, writable only while the channel is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                white_q[c] <= '0;
                m_q[c]     <= 7'd8;
                img_q[c]   <= 10'd256;
                thr_q[c]   <= '0;
                amin_q[c]  <= '0;
                amax_q[c]  <= '0;
                bmin_q[c]  <= '0;
                bmax_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_wr[c] && state_q[c] == ST_IDLE) begin
                    case (addr_idx)
                        IDX_WHITE: white_q[c] <= PWDATA[DATA_DEPTH-1:0];
                        IDX_M:     m_q[c]     <= PWDATA[6:0];
                        IDX_IMG:   img_q[c]   <= PWDATA[9:0];
                        IDX_THR:   thr_q[c]   <= PWDATA[7:0];
                        IDX_AMIN:  amin_q[c]  <= PWDATA[6:0];
                        IDX_AMAX:  amax_q[c]  <= PWDATA[6:0];
                        IDX_BMIN:  bmin_q[c]  <= PWDATA[5:0];
                        IDX_BMAX:  bmax_q[c]  <= PWDATA[5:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Read mux: zero-extended field of the addressed channel, 0 when invalid
    always_comb begin
        rd_data_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_ch[c]) begin
                case (addr_idx)
                    IDX_WHITE:  rd_data_d = AMBA_WORD'(white_q[c]);
                    IDX_M:      rd_data_d = AMBA_WORD'(m_q[c]);
                    IDX_IMG:    rd_data_d = AMBA_WORD'(img_q[c]);
                    IDX_THR:    rd_data_d = AMBA_WORD'(thr_q[c]);
                    IDX_AMIN:   rd_data_d = AMBA_WORD'(amin_q[c]);
                    IDX_AMAX:   rd_data_d = AMBA_WORD'(amax_q[c]);
                    IDX_BMIN:   rd_data_d = AMBA_WORD'(bmin_q[c]);
                    IDX_BMAX:   rd_data_d = AMBA_WORD'(bmax_q[c]);
                    IDX_STATUS: rd_data_d = AMBA_WORD'({err_q[c], done_q[c], state_q[c] == ST_BUSY});
                    default:    rd_data_d = '0;
                endcase
            end
        end
    end

    // PRDATA captured in the read setup cycle, held through access, else 0
    always_ff @(posedge clk) begin
        if (rst) begin
            prdata_q <= '0;
        end else if (rd_setup) begin
            prdata_q <= rd_data_d;
        end else if (!rd_access) begin
            prdata_q <= '0;
        end
    end

    assign PRDATA = prdata_q;
    assign start  = start_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign busy[g]                                = (state_q[g] == ST_BUSY);
        assign WhitePixel[g*DATA_DEPTH +: DATA_DEPTH] = white_q[g];
        assign M[g*7 +: 7]                            = m_q[g];
        assign ImgSize[g*10 +: 10]                    = img_q[g];
        assign EdgeThr[g*8 +: 8]                      = thr_q[g];
        assign Amin[g*7 +: 7]                         = amin_q[g];
        assign Amax[g*7 +: 7]                         = amax_q[g];
        assign Bmin[g*6 +: 6]                         = bmin_q[g];
        assign Bmax[g*6 +: 6]                         = bmax_q[g];
    end

`ifdef WM_CFG_PSLVERR_EN
    logic busy_sel;
    logic cfg_ok_sel;
    logic slverr_d;

    assign busy_sel   = |(sel_ch & busy);
    assign cfg_ok_sel = |(sel_ch & cfg_ok);

    // Error response during the access cycle of any rejected transfer
    always_comb begin
        slverr_d = 1'b0;
        if (PSEL && PENABLE) begin
            if (!addr_ok) begin
                slverr_d = 1'b1;
            end else if (PWRITE) begin
                if (addr_idx == IDX_STATUS) begin
                    slverr_d = 1'b1;
                end else if (addr_idx == IDX_CTRL) begin
                    slverr_d = PWDATA[0] && (busy_sel || !cfg_ok_sel);
                end else begin
                    slverr_d = busy_sel;
                end
            end
        end
    end

    assign PSLVERR = slverr_d;
`endif

endmodule
